addr_manager_mq: RTL and testbench
==================================

Name: addr_manager_mq

Overview:
Multi-queue buffer address manager. It is the parametrised successor of the single-list address manager. One shared free list and NUM_QUEUES per-queue linked lists live in a single link table. The table is self-initialised after reset, so no memory init file is needed. It sits between the packet buffer write/read controllers and the scheduler: enqueue allocates a cell address into queue q, dequeue pops queue q's head and returns that cell to the free list.

Parameters:
ADDR_WIDTH, 12, cell address width
ADDR_TABLE_DEPTH, 4096, number of cells; must equal 2**ADDR_WIDTH
NUM_QUEUES, 4, number of logical queues (>=1)
QID_WIDTH, 2, queue id width; 2**QID_WIDTH >= NUM_QUEUES
THRESHOLD_ALMOST_FULL, 48, almost-full asserted when free cells < this

Ports:
clk  in  1  clock
rstn  in  1  reset
s_axis_enq_valid  in  1  enqueue request
s_axis_enq_qid  in  QID_WIDTH  target queue
s_axis_enq_ready  out  1  enqueue accepted this cycle when valid&ready
m_axis_enq_addr  out  ADDR_WIDTH  allocated cell; valid in the handshake cycle
s_axis_deq_valid  in  1  dequeue request
s_axis_deq_qid  in  QID_WIDTH  source queue
s_axis_deq_ready  out  1  dequeue accepted
m_axis_deq_addr  out  ADDR_WIDTH  popped cell; valid in the handshake cycle
m_axis_q_empty  out  NUM_QUEUES  per-queue empty flags
m_axis_remain_space  out  ADDR_WIDTH+1  free cell count
m_axis_almost_full  out  1  remain_space < THRESHOLD_ALMOST_FULL
m_axis_init_done  out  1  link table initialised; operations allowed

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rstn sampled on posedge clk). Reset may assert in any cycle, including mid-init or mid-operation, and discards all queue contents.
- Reset values: readies 0; init_done 0; q_empty all 1; remain_space = ADDR_TABLE_DEPTH; almost_full 0; fl_head 0; fl_tail DEPTH-1; init counter 0; arbitration pointer = dequeue.
- FSM has two states.
  - INIT: writes link[i] = i+1 (mod DEPTH) at one entry per cycle, for i = 0..DEPTH-1. After the final write it moves to RUN. Init lasts exactly DEPTH cycles after reset deasserts; readies stay 0 throughout.
  - RUN: init_done = 1. It never leaves RUN except on reset.
- One operation per cycle. The link table has one asynchronous read port and one synchronous write port.
- Eligibility:
  - enq_ok = valid & remain_space != 0.
  - deq_ok = valid & !q_empty[deq_qid].
  - If only one is ok, it is granted.
  - If both are ok, round-robin applies: the grant alternates, and the pointer toggles only on a contested grant.
  - ready is asserted only for the granted side; it is combinational from valid/qid/state.
  - qid >= NUM_QUEUES is never ready.
- Enqueue on q:
  - m_axis_enq_addr = fl_head; fl_head <= link[fl_head].
  - If q nonempty: link[q_tail[q]] <= fl_head.
  - If q empty: q_head[q] <= fl_head.
  - q_tail[q] <= fl_head; remain_space - 1.
- Dequeue on q:
  - m_axis_deq_addr = q_head[q]; q_head[q] <= link[q_head[q]].
  - q becomes empty when head == tail before the pop.
  - Freed cell appended: if remain_space != 0, link[fl_tail] <= cell; else fl_head <= cell.
  - fl_tail <= cell; remain_space + 1.
- Output addresses are combinational, with zero latency; all state updates at the next edge.
- Queue membership has no count limit other than total cells; remain_space never exceeds DEPTH or drops below 0 under legal use.

Optional Feature:
ADDR_MANAGER_QSTATS_EN
- Defined: adds output m_axis_q_count (NUM_QUEUES*(ADDR_WIDTH+1)). Per-queue occupancy counters: reset 0, +1 on enqueue, -1 on dequeue. q_empty is derived as count == 0.
- Undefined: port absent; q_empty is held as a per-queue flag register, set on popping the last entry and cleared on enqueue. Externally visible behaviour is otherwise identical.

Decomposition:
- Package addr_manager_pkg holds:
  - state encoding (INIT, RUN)
  - grant encoding
  - typedef cell_addr_t [ADDR_WIDTH-1:0]
  - typedef cell_cnt_t [ADDR_WIDTH:0]
- Sub-module addr_link_ram: DEPTH x ADDR_WIDTH; async read (raddr/rdata); sync write (we/waddr/wdata). Its write port is muxed between the INIT counter and RUN operations.

Test Plan (ADDR_WIDTH=4, DEPTH=16, NUM_QUEUES=4, THRESHOLD=4 unless noted):
- Release rstn -> readies 0 for 16 cycles; init_done = 1 on cycle 17; remain_space = 16; q_empty = 4'b1111.
- Enqueue q0 x3 -> enq_addr 0, 1, 2; remain_space 13; q_empty[0] = 0. Dequeue q0 x3 -> deq_addr 0, 1, 2; q_empty[0] = 1; remain_space 16.
- Interleave enqueues q1, q2, q1, q2 -> addrs 0, 1, 2, 3. Dequeue q2 -> 1, then q1 -> 0. Next enqueues -> 4..15 then 1, 0 (freed cells reused in FIFO order).
- Hold enq and deq valid continuously on q3 (q3 nonempty) -> grants alternate deq, enq, deq, enq; remain_space constant.
- Enqueue 16 cells -> almost_full asserts when remain_space = 3; enq_ready = 0 at 0. Dequeue one -> fl_head = fl_tail = returned cell; next enqueue gets that cell.
- Assert rstn low during RUN with queues nonempty, and separately at init cycle 7 -> full re-init (16 cycles); all queues empty; first enqueue returns 0.

Source files
------------

// File: rtl/addr_manager_pkg.sv
// Shared encodings and cell types for the multi-queue buffer address manager.
package addr_manager_pkg;

  localparam int unsigned CELL_ADDR_WIDTH = 12;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [0:0] GNT_DEQ = 1'b0;
  localparam logic [0:0] GNT_ENQ = 1'b1;

  typedef logic [CELL_ADDR_WIDTH-1:0] cell_addr_t;
  typedef logic [CELL_ADDR_WIDTH:0]   cell_cnt_t;

endpackage

// File: rtl/addr_manager_mq_if.sv
// Enqueue/dequeue/status bundle between the address manager and its clients.
// m_axis_q_count exists only when ADDR_MANAGER_QSTATS_EN is defined.
interface addr_manager_mq_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_QUEUES = 4,
  parameter int unsigned QID_WIDTH  = 2
);

  logic                    s_axis_enq_valid;
  logic [QID_WIDTH-1:0]    s_axis_enq_qid;
  logic                    s_axis_enq_ready;
  logic [ADDR_WIDTH-1:0]   m_axis_enq_addr;
  logic                    s_axis_deq_valid;
  logic [QID_WIDTH-1:0]    s_axis_deq_qid;
  logic                    s_axis_deq_ready;
  logic [ADDR_WIDTH-1:0]   m_axis_deq_addr;
  logic [NUM_QUEUES-1:0]   m_axis_q_empty;
  logic [ADDR_WIDTH:0]     m_axis_remain_space;
  logic                    m_axis_almost_full;
  logic                    m_axis_init_done;
`ifdef ADDR_MANAGER_QSTATS_EN
  logic [NUM_QUEUES*(ADDR_WIDTH+1)-1:0] m_axis_q_count;
`endif

  modport slave (
    input  s_axis_enq_valid, s_axis_enq_qid, s_axis_deq_valid, s_axis_deq_qid,
    output s_axis_enq_ready, m_axis_enq_addr, s_axis_deq_ready, m_axis_deq_addr,
    output m_axis_q_empty, m_axis_remain_space, m_axis_almost_full, m_axis_init_done
`ifdef ADDR_MANAGER_QSTATS_EN
    , output m_axis_q_count
`endif
  );

  modport master (
    output s_axis_enq_valid, s_axis_enq_qid, s_axis_deq_valid, s_axis_deq_qid,
    input  s_axis_enq_ready, m_axis_enq_addr, s_axis_deq_ready, m_axis_deq_addr,
    input  m_axis_q_empty, m_axis_remain_space, m_axis_almost_full, m_axis_init_done
`ifdef ADDR_MANAGER_QSTATS_EN
    , input m_axis_q_count
`endif
  );

endinterface

// File: rtl/addr_link_ram.sv
// Next-pointer table: one asynchronous read port, one synchronous write port.
module addr_link_ram #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [ADDR_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [ADDR_WIDTH-1:0] o_rdata
);

  logic [ADDR_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/addr_manager_mq.sv
// Multi-queue cell address manager: shared free list plus per-queue linked lists.
// Optional per-queue occupancy counters under ADDR_MANAGER_QSTATS_EN.
module addr_manager_mq
  import addr_manager_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH            = 12,
  parameter int unsigned ADDR_TABLE_DEPTH      = 4096,
  parameter int unsigned NUM_QUEUES            = 4,
  parameter int unsigned QID_WIDTH             = 2,
  parameter int unsigned THRESHOLD_ALMOST_FULL = 48
) (
  input  logic             clk,
  input  logic             rstn,
  addr_manager_mq_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [0:0]            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_cnt, w_init_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_fl_head, r_fl_tail;
  logic [CNT_W-1:0]      r_remain, w_remain_nxt;
  logic                  r_almost_full;
  logic [0:0]            r_rr_ptr;
  logic [ADDR_WIDTH-1:0] r_q_head [NUM_QUEUES];
  logic [ADDR_WIDTH-1:0] r_q_tail [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] w_q_empty;

  logic                  w_run, w_enq_ok, w_deq_ok, w_gnt_enq, w_gnt_deq;
  logic                  w_enq_q_empty, w_deq_q_empty;
  logic [ADDR_WIDTH-1:0] w_enq_q_tail, w_deq_q_head;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr, w_wdata, w_raddr, w_link_rdata;

  // Init walks the table once, then stays in RUN until reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    case (r_state)
      ST_INIT: begin
        w_init_cnt_nxt = r_init_cnt + 1'b1;
        if (r_init_cnt == ADDR_WIDTH'(ADDR_TABLE_DEPTH - 1)) w_state_nxt = ST_RUN;
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_run = (r_state == ST_RUN);

  // Per-queue state selected by the request qids; out-of-range qids look empty
  always_comb begin
    w_enq_q_empty = 1'b1;
    w_enq_q_tail  = '0;
    w_deq_q_empty = 1'b1;
    w_deq_q_head  = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (bus.s_axis_enq_qid == QID_WIDTH'(i)) begin
        w_enq_q_empty = w_q_empty[i];
        w_enq_q_tail  = r_q_tail[i];
      end
      if (bus.s_axis_deq_qid == QID_WIDTH'(i)) begin
        w_deq_q_empty = w_q_empty[i];
        w_deq_q_head  = r_q_head[i];
      end
    end
  end

  assign w_enq_ok = w_run & bus.s_axis_enq_valid & (r_remain != '0)
                  & (32'(bus.s_axis_enq_qid) < NUM_QUEUES);
  assign w_deq_ok = w_run & bus.s_axis_deq_valid & ~w_deq_q_empty
                  & (32'(bus.s_axis_deq_qid) < NUM_QUEUES);

  assign w_gnt_enq = w_enq_ok & (~w_deq_ok | (r_rr_ptr == GNT_ENQ));
  assign w_gnt_deq = w_deq_ok & ~w_gnt_enq;

  assign w_remain_nxt = w_gnt_enq ? r_remain - 1'b1 :
                        w_gnt_deq ? r_remain + 1'b1 : r_remain;

  // Table write port: init fill, queue-tail link on enqueue, free-tail link on dequeue
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!w_run) begin
      w_we    = rstn;
      w_waddr = r_init_cnt;
      w_wdata = r_init_cnt + 1'b1;
    end else if (w_gnt_enq && !w_enq_q_empty) begin
      w_we    = rstn;
      w_waddr = w_enq_q_tail;
      w_wdata = r_fl_head;
    end else if (w_gnt_deq && (r_remain != '0)) begin
      w_we    = rstn;
      w_waddr = r_fl_tail;
      w_wdata = w_deq_q_head;
    end
  end

  assign w_raddr = w_gnt_enq ? r_fl_head : w_deq_q_head;

  addr_link_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (ADDR_TABLE_DEPTH)
  ) u_link_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_link_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fl_head     <= '0;
      r_fl_tail     <= ADDR_WIDTH'(ADDR_TABLE_DEPTH - 1);
      r_remain      <= CNT_W'(ADDR_TABLE_DEPTH);
      r_almost_full <= 1'b0;
      r_rr_ptr      <= GNT_DEQ;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        r_q_head[i] <= '0;
        r_q_tail[i] <= '0;
      end
    end else begin
      r_remain      <= w_remain_nxt;
      r_almost_full <= (32'(w_remain_nxt) < THRESHOLD_ALMOST_FULL);
      if (w_enq_ok && w_deq_ok) r_rr_ptr <= ~r_rr_ptr;
      if (w_gnt_enq) begin
        r_fl_head <= w_link_rdata;
        for (int i = 0; i < NUM_QUEUES; i++) begin
          if (bus.s_axis_enq_qid == QID_WIDTH'(i)) begin
            if (w_enq_q_empty) r_q_head[i] <= r_fl_head;
            r_q_tail[i] <= r_fl_head;
          end
        end
      end
      if (w_gnt_deq) begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
          if (bus.s_axis_deq_qid == QID_WIDTH'(i)) r_q_head[i] <= w_link_rdata;
        end
        // Freed cell restarts the free list when it was exhausted
        if (r_remain == '0) r_fl_head <= w_deq_q_head;
        r_fl_tail <= w_deq_q_head;
      end
    end
  end

`ifdef ADDR_MANAGER_QSTATS_EN
  logic [CNT_W-1:0] r_q_count [NUM_QUEUES];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (!rstn) begin
        r_q_count[i] <= '0;
      end else if (w_gnt_enq && (bus.s_axis_enq_qid == QID_WIDTH'(i))) begin
        r_q_count[i] <= r_q_count[i] + 1'b1;
      end else if (w_gnt_deq && (bus.s_axis_deq_qid == QID_WIDTH'(i))) begin
        r_q_count[i] <= r_q_count[i] - 1'b1;
      end
    end
  end

  always_comb begin
    w_q_empty          = '0;
    bus.m_axis_q_count = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      w_q_empty[i]                          = (r_q_count[i] == '0);
      bus.m_axis_q_count[i*CNT_W +: CNT_W] = r_q_count[i];
    end
  end
`else
  logic [NUM_QUEUES-1:0] r_q_empty;
  logic [ADDR_WIDTH-1:0] w_deq_q_tail;

  always_comb begin
    w_deq_q_tail = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (bus.s_axis_deq_qid == QID_WIDTH'(i)) w_deq_q_tail = r_q_tail[i];
    end
  end

  // Popping the entry where head meets tail drains the queue
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (!rstn) begin
        r_q_empty[i] <= 1'b1;
      end else if (w_gnt_enq && (bus.s_axis_enq_qid == QID_WIDTH'(i))) begin
        r_q_empty[i] <= 1'b0;
      end else if (w_gnt_deq && (bus.s_axis_deq_qid == QID_WIDTH'(i))
                   && (w_deq_q_head == w_deq_q_tail)) begin
        r_q_empty[i] <= 1'b1;
      end
    end
  end

  assign w_q_empty = r_q_empty;
`endif

  assign bus.s_axis_enq_ready    = w_gnt_enq;
  assign bus.s_axis_deq_ready    = w_gnt_deq;
  assign bus.m_axis_enq_addr     = r_fl_head;
  assign bus.m_axis_deq_addr     = w_deq_q_head;
  assign bus.m_axis_q_empty      = w_q_empty;
  assign bus.m_axis_remain_space = r_remain;
  assign bus.m_axis_almost_full  = r_almost_full;
  assign bus.m_axis_init_done    = w_run;

endmodule

// File: tb/tb_addr_manager_mq.sv
// Bench for addr_manager_mq: directed scenarios plus random traffic checked
// against a queue-based model of the free list and per-queue FIFOs.
module tb_addr_manager_mq;
  import addr_manager_pkg::*;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NQ    = 4;
  localparam int unsigned QW    = 2;
  localparam int unsigned THR   = 4;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  addr_manager_mq_if #(.ADDR_WIDTH(AW), .NUM_QUEUES(NQ), .QID_WIDTH(QW)) bus ();

  addr_manager_mq #(
    .ADDR_WIDTH            (AW),
    .ADDR_TABLE_DEPTH      (DEPTH),
    .NUM_QUEUES            (NQ),
    .QID_WIDTH             (QW),
    .THRESHOLD_ALMOST_FULL (THR)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: free list and each queue are plain FIFOs of cell numbers
  int fq[$];
  int qq[NQ][$];
  bit pref_deq;
  int obs_enq, obs_deq;
  bit last_gnt_enq, last_gnt_deq;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    for (int i = 0; i < DEPTH; i++) fq.push_back(i);
    for (int q = 0; q < NQ; q++) qq[q].delete();
    pref_deq = 1'b1;
  endtask

  task automatic check_status();
    logic [NQ-1:0] exp_empty;
    for (int q = 0; q < NQ; q++) exp_empty[q] = (qq[q].size() == 0);
    check_val("remain_space", 32'(bus.m_axis_remain_space), fq.size());
    check_val("q_empty", 32'(bus.m_axis_q_empty), 32'(exp_empty));
    check_val("almost_full", 32'(bus.m_axis_almost_full), 32'(fq.size() < THR));
    check_val("init_done", 32'(bus.m_axis_init_done), 1);
`ifdef ADDR_MANAGER_QSTATS_EN
    for (int q = 0; q < NQ; q++)
      check_val("q_count", 32'(bus.m_axis_q_count[q*(AW+1) +: AW+1]), qq[q].size());
`endif
  endtask

  // One RUN cycle: drive after the falling edge, check, commit to the model
  task automatic do_cycle(bit ev, int eq, bit dv, int dq);
    bit eok, dok, ge, gd;
    @(negedge clk);
    bus.s_axis_enq_valid = ev;
    bus.s_axis_enq_qid   = QW'(eq);
    bus.s_axis_deq_valid = dv;
    bus.s_axis_deq_qid   = QW'(dq);
    #1;
    eok = ev && (fq.size() > 0);
    dok = dv && (qq[dq].size() > 0);
    if (eok && dok) begin
      ge = !pref_deq;
      pref_deq = !pref_deq;
    end else begin
      ge = eok;
    end
    gd = dok && !ge;
    check_val("enq_ready", 32'(bus.s_axis_enq_ready), 32'(ge));
    check_val("deq_ready", 32'(bus.s_axis_deq_ready), 32'(gd));
    check_status();
    if (ge) begin
      check_val("enq_addr", 32'(bus.m_axis_enq_addr), fq[0]);
      obs_enq = int'(bus.m_axis_enq_addr);
      qq[eq].push_back(fq.pop_front());
    end
    if (gd) begin
      check_val("deq_addr", 32'(bus.m_axis_deq_addr), qq[dq][0]);
      obs_deq = int'(bus.m_axis_deq_addr);
      fq.push_back(qq[dq].pop_front());
    end
    last_gnt_enq = ge;
    last_gnt_deq = gd;
  endtask

  task automatic idle();
    do_cycle(1'b0, 0, 1'b0, 0);
  endtask

  // Reset, then watch the init window; abort_at>0 stops early inside init
  task automatic do_reset(int abort_at);
    @(negedge clk);
    rstn = 1'b0;
    bus.s_axis_enq_valid = 1'b1;
    bus.s_axis_deq_valid = 1'b1;
    bus.s_axis_enq_qid   = '0;
    bus.s_axis_deq_qid   = '0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_val("rst_remain", 32'(bus.m_axis_remain_space), DEPTH);
    check_val("rst_q_empty", 32'(bus.m_axis_q_empty), 32'hF);
    check_val("rst_almost_full", 32'(bus.m_axis_almost_full), 0);
    check_val("rst_init_done", 32'(bus.m_axis_init_done), 0);
    check_val("rst_enq_ready", 32'(bus.s_axis_enq_ready), 0);
    check_val("rst_deq_ready", 32'(bus.s_axis_deq_ready), 0);
    for (int c = 2; c <= DEPTH; c++) begin
      @(negedge clk);
      #1;
      check_val("init_done_low", 32'(bus.m_axis_init_done), 0);
      check_val("init_enq_ready", 32'(bus.s_axis_enq_ready), 0);
      if (c == abort_at) return;
    end
    @(negedge clk);
    #1;
    check_val("init_done_17", 32'(bus.m_axis_init_done), 1);
    check_val("run_enq_ready", 32'(bus.s_axis_enq_ready), 1);
    check_val("run_enq_addr", 32'(bus.m_axis_enq_addr), 0);
    bus.s_axis_enq_valid = 1'b0;
    bus.s_axis_deq_valid = 1'b0;
    model_reset();
  endtask

  initial begin
    int pe, pd;
    rstn = 1'b1;
    bus.s_axis_enq_valid = 1'b0;
    bus.s_axis_deq_valid = 1'b0;
    bus.s_axis_enq_qid   = '0;
    bus.s_axis_deq_qid   = '0;
    model_reset();

    do_reset(0);
    idle();

    // Single queue fill and drain
    for (int k = 0; k < 3; k++) do_cycle(1'b1, 0, 1'b0, 0);
    check_val("plan_enq_last", obs_enq, 2);
    idle();
    check_val("plan_remain13", 32'(bus.m_axis_remain_space), 13);
    for (int k = 0; k < 3; k++) do_cycle(1'b0, 0, 1'b1, 0);
    check_val("plan_deq_last", obs_deq, 2);
    idle();

    // Interleaved queues, then freed cells reused in FIFO order
    do_reset(0);
    do_cycle(1'b1, 1, 1'b0, 0);
    do_cycle(1'b1, 2, 1'b0, 0);
    do_cycle(1'b1, 1, 1'b0, 0);
    do_cycle(1'b1, 2, 1'b0, 0);
    check_val("interleave_enq", obs_enq, 3);
    do_cycle(1'b0, 0, 1'b1, 2);
    check_val("deq_q2", obs_deq, 1);
    do_cycle(1'b0, 0, 1'b1, 1);
    check_val("deq_q1", obs_deq, 0);
    for (int k = 0; k < 14; k++) begin
      do_cycle(1'b1, k % NQ, 1'b0, 0);
      if (k == 11) check_val("reuse_pre", obs_enq, 15);
      if (k == 12) check_val("reuse_first", obs_enq, 1);
    end
    check_val("reuse_second", obs_enq, 0);
    do_cycle(1'b1, 0, 1'b0, 0);
    check_val("full_no_grant", 32'(bus.s_axis_enq_ready), 0);

    // Contested requests on one nonempty queue alternate
    do_reset(0);
    do_cycle(1'b1, 3, 1'b0, 0);
    do_cycle(1'b1, 3, 1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      do_cycle(1'b1, 3, 1'b1, 3);
      check_val("rr_deq_turn", 32'(last_gnt_deq), 32'(k % 2 == 0));
    end
    idle();
    check_val("rr_remain", 32'(bus.m_axis_remain_space), 14);

    // Exhaust the free list, then recycle one cell
    do_reset(0);
    for (int k = 0; k < 16; k++) begin
      do_cycle(1'b1, k % NQ, 1'b0, 0);
      if (k == 12) check_val("af_low_at4", 32'(bus.m_axis_almost_full), 0);
    end
    idle();
    check_val("af_high_at0", 32'(bus.m_axis_almost_full), 1);
    do_cycle(1'b1, 1, 1'b0, 0);
    do_cycle(1'b0, 0, 1'b1, 2);
    do_cycle(1'b1, 1, 1'b0, 0);
    check_val("recycle_cell", obs_enq, 2);
    idle();

    // Reset with queues populated, and reset in the middle of init
    do_reset(0);
    idle();
    do_cycle(1'b1, 0, 1'b0, 0);
    check_val("post_run_reset_enq", obs_enq, 0);
    do_reset(7);
    do_reset(0);
    do_cycle(1'b1, 2, 1'b0, 0);
    check_val("post_init_reset_enq", obs_enq, 0);

    // Random traffic with alternating fill/drain bias
    for (int ph = 0; ph < 12; ph++) begin
      pe = (ph % 2 == 0) ? 80 : 35;
      pd = (ph % 2 == 0) ? 40 : 85;
      for (int k = 0; k < 200; k++) begin
        do_cycle($urandom_range(0, 99) < pe, $urandom_range(0, NQ - 1),
                 $urandom_range(0, 99) < pd, $urandom_range(0, NQ - 1));
      end
      if (ph == 5) do_reset(0);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
